// File: rtl/dm_param_bytelane.sv
// rtl/dm_param_bytelane.sv - clocked byte/halfword/word data memory with init sequencer
//
// Purpose: MEM-stage data memory. Little-endian byte-addressed array of
// DEPTH_WORDS 32-bit words with sb/sh/sw stores, signed/unsigned lb/lh and lw
// loads, alignment and range checking, and a one-cycle registered read.
// After reset an init sequencer zeroes the array while ready is low.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req          access request (accepted when req && ready)
//   we           1 = store, 0 = load
//   size         00 byte, 01 halfword, 10 word, 11 reserved (always errors)
//   unsigned_ld  1 = zero-extend byte/halfword loads, 0 = sign-extend
//   addr         byte address
//   din          right-justified store data
//   dout         registered load result, held until the next accepted load
//   rvalid       one-cycle pulse, dout updated
//   ready        block can accept a request
//   addr_err     one-cycle pulse, previous accepted access was rejected
module dm_param_bytelane #(
  parameter int DEPTH_WORDS   = 1024,
  parameter int ADDR_W        = 12,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              rvalid,
  output logic              ready,
  output logic              addr_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic {S_INIT, S_IDLE} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_init_ptr, w_init_ptr_nxt;
  logic             w_ready;

  logic [31:0]      r_mem [DEPTH_WORDS];
  logic [31:0]      r_dout;
  logic             r_rvalid;
  logic             r_err;

  logic [IDX_W-1:0] w_idx;
  logic [ADDR_W-1:0] w_hi;
  logic             w_oor;
  logic             w_misalign;
  logic             w_err;
  logic             w_acc;

  logic [IDX_W-1:0] w_mem_idx;
  logic [3:0]       w_mem_be;
  logic [31:0]      w_mem_wdata;

  logic [31:0]      w_rd_word;
  logic [7:0]       w_rd_byte;
  logic [15:0]      w_rd_half;
  logic [31:0]      w_ld_data;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= INIT_ON_RESET ? S_INIT : S_IDLE;
      r_init_ptr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_ptr <= w_init_ptr_nxt;
    end
  end

  // FSM next state and ready
  always_comb begin
    w_state_nxt    = r_state;
    w_init_ptr_nxt = r_init_ptr;
    w_ready        = 1'b0;
    case (r_state)
      S_INIT: begin
        w_init_ptr_nxt = r_init_ptr + IDX_W'(1);
        if (r_init_ptr == IDX_W'(DEPTH_WORDS - 1)) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_IDLE: begin
        w_ready = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Decode and error checks. The low index bits alias into the array even for
  // out-of-range addresses, so the error must gate every side effect.
  assign w_idx = addr[IDX_W+1:2];
  assign w_hi  = addr >> (IDX_W + 2);
  assign w_oor = |w_hi;

  always_comb begin
    w_misalign = 1'b0;
    case (size)
      2'b00:   w_misalign = 1'b0;
      2'b01:   w_misalign = addr[0];
      2'b10:   w_misalign = |addr[1:0];
      default: w_misalign = 1'b1;
    endcase
  end

  assign w_err = w_oor | w_misalign;
  assign w_acc = req & w_ready;

  // Single write port shared by the init sequencer and stores; an all-zero
  // byte enable means no write this cycle.
  always_comb begin
    w_mem_idx   = w_idx;
    w_mem_be    = 4'b0000;
    w_mem_wdata = din;
    if (r_state == S_INIT) begin
      w_mem_idx   = r_init_ptr;
      w_mem_be    = 4'b1111;
      w_mem_wdata = 32'h0;
    end else if (w_acc && we && !w_err) begin
      case (size)
        2'b00: begin
          w_mem_be    = 4'b0001 << addr[1:0];
          w_mem_wdata = {4{din[7:0]}};
        end
        2'b01: begin
          w_mem_be    = addr[1] ? 4'b1100 : 4'b0011;
          w_mem_wdata = {2{din[15:0]}};
        end
        default: begin
          w_mem_be    = 4'b1111;
          w_mem_wdata = din;
        end
      endcase
    end
  end

  // Array storage is deliberately outside reset; init clears it instead.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_mem_be[b]) begin
        r_mem[w_mem_idx][b*8 +: 8] <= w_mem_wdata[b*8 +: 8];
      end
    end
  end

  // Load extraction uses the same lane mapping as stores
  assign w_rd_word = r_mem[w_idx];

  always_comb begin
    w_rd_byte = w_rd_word[7:0];
    case (addr[1:0])
      2'b00:   w_rd_byte = w_rd_word[7:0];
      2'b01:   w_rd_byte = w_rd_word[15:8];
      2'b10:   w_rd_byte = w_rd_word[23:16];
      default: w_rd_byte = w_rd_word[31:24];
    endcase
  end

  assign w_rd_half = addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];

  always_comb begin
    w_ld_data = w_rd_word;
    case (size)
      2'b00:   w_ld_data = unsigned_ld ? {24'h0, w_rd_byte}
                                       : {{24{w_rd_byte[7]}}, w_rd_byte};
      2'b01:   w_ld_data = unsigned_ld ? {16'h0, w_rd_half}
                                       : {{16{w_rd_half[15]}}, w_rd_half};
      default: w_ld_data = w_rd_word;
    endcase
  end

  // Registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout   <= 32'h0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_rvalid <= w_acc & ~we;
      r_err    <= w_acc & w_err;
      if (w_acc && !we) begin
        r_dout <= w_err ? 32'h0 : w_ld_data;
      end
    end
  end

  assign dout     = r_dout;
  assign rvalid   = r_rvalid;
  assign ready    = w_ready;
  assign addr_err = r_err;

endmodule

// File: tb/tb_dm_param_bytelane.sv
// tb/tb_dm_param_bytelane.sv - directed self-checking bench for dm_param_bytelane
module tb_dm_param_bytelane;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic          we;
  logic [1:0]    size;
  logic          unsigned_ld;
  logic [AW-1:0] addr;
  logic [31:0]   din;
  logic [31:0]   dout;
  logic          rvalid;
  logic          ready;
  logic          addr_err;

  int n_tests = 0;
  int n_fail  = 0;

  dm_param_bytelane #(
    .DEPTH_WORDS  (1024),
    .ADDR_W       (AW),
    .INIT_ON_RESET(1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .we         (we),
    .size       (size),
    .unsigned_ld(unsigned_ld),
    .addr       (addr),
    .din        (din),
    .dout       (dout),
    .rvalid     (rvalid),
    .ready      (ready),
    .addr_err   (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic u,
                        input logic [AW-1:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = sz; unsigned_ld = u; addr = a; din = d;
    tick();
    req = 1'b0;
  endtask

  task automatic ld(input string tag, input logic [1:0] sz, input logic u,
                    input logic [AW-1:0] a, input logic [31:0] exp_d, input logic exp_e);
    access(1'b0, sz, u, a, 32'h0);
    check({tag, ".dout"}, dout, exp_d);
    check({tag, ".rvalid"}, {31'h0, rvalid}, 32'h1);
    check({tag, ".err"}, {31'h0, addr_err}, {31'h0, exp_e});
  endtask

  task automatic st(input string tag, input logic [1:0] sz,
                    input logic [AW-1:0] a, input logic [31:0] d, input logic exp_e);
    access(1'b1, sz, 1'b0, a, d);
    check({tag, ".rvalid"}, {31'h0, rvalid}, 32'h0);
    check({tag, ".err"}, {31'h0, addr_err}, {31'h0, exp_e});
  endtask

  // Counts cycles until ready rises, bounded; also counts stray pulses.
  task automatic wait_init(input string tag);
    int n = 0;
    int pulses = 0;
    check({tag, ".ready_lo"}, {31'h0, ready}, 32'h0);
    while (!ready && n < 1100) begin
      tick();
      n++;
      if (rvalid || addr_err) pulses++;
    end
    req = 1'b0;
    check({tag, ".init_cycles"}, n, 32'd1024);
    check({tag, ".init_pulses"}, pulses, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b10; unsigned_ld = 1'b0;
    addr = '0; din = 32'h0;
    repeat (3) tick();
    check("rst.dout", dout, 32'h0);
    check("rst.rvalid", {31'h0, rvalid}, 32'h0);
    check("rst.err", {31'h0, addr_err}, 32'h0);
    check("rst.ready", {31'h0, ready}, 32'h0);

    // Store request held high throughout init must be ignored
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 13'h040; din = 32'hDEADBEEF;
    rst_n = 1'b1;
    wait_init("init1");
    ld("init.lw40", 2'b10, 1'b0, 13'h040, 32'h0, 1'b0);
    ld("init.lw3fc", 2'b10, 1'b0, 13'h3FC, 32'h0, 1'b0);

    // Byte loads
    st("sw10", 2'b10, 13'h010, 32'h80FF7F01, 1'b0);
    ld("lb10", 2'b00, 1'b0, 13'h010, 32'h00000001, 1'b0);
    ld("lb11", 2'b00, 1'b0, 13'h011, 32'h0000007F, 1'b0);
    ld("lb12", 2'b00, 1'b0, 13'h012, 32'hFFFFFFFF, 1'b0);
    ld("lb13", 2'b00, 1'b0, 13'h013, 32'hFFFFFF80, 1'b0);
    ld("lbu12", 2'b00, 1'b1, 13'h012, 32'h000000FF, 1'b0);
    ld("lbu13", 2'b00, 1'b1, 13'h013, 32'h00000080, 1'b0);
    st("sb11", 2'b00, 13'h011, 32'hFFFFFF33, 1'b0);
    ld("lw10b", 2'b10, 1'b0, 13'h010, 32'h80FF3301, 1'b0);

    // Halfword merge over an existing word
    st("sw20", 2'b10, 13'h020, 32'h11111111, 1'b0);
    st("sh22", 2'b01, 13'h022, 32'h1234BEEF, 1'b0);
    ld("lw20", 2'b10, 1'b0, 13'h020, 32'hBEEF1111, 1'b0);
    ld("lh22", 2'b01, 1'b0, 13'h022, 32'hFFFFBEEF, 1'b0);
    ld("lhu22", 2'b01, 1'b1, 13'h022, 32'h0000BEEF, 1'b0);
    ld("lh20", 2'b01, 1'b0, 13'h020, 32'h00001111, 1'b0);

    // Error cases
    ld("e.lw21", 2'b10, 1'b0, 13'h021, 32'h0, 1'b1);
    st("e.sh23", 2'b01, 13'h023, 32'h00000000, 1'b1);
    ld("e.sz11", 2'b11, 1'b0, 13'h020, 32'h0, 1'b1);
    st("e.sz11st", 2'b11, 13'h020, 32'h00000000, 1'b1);
    ld("e.lw1000", 2'b10, 1'b0, 13'h1000, 32'h0, 1'b1);
    st("e.sw1020", 2'b10, 13'h1020, 32'h00000000, 1'b1);
    ld("e.after", 2'b10, 1'b0, 13'h020, 32'hBEEF1111, 1'b0);
    tick();
    check("idle.rvalid", {31'h0, rvalid}, 32'h0);
    check("idle.err", {31'h0, addr_err}, 32'h0);
    check("idle.hold", dout, 32'hBEEF1111);

    // Back-to-back store then load of the same word
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 13'h040; din = 32'hA5A5A5A5;
    tick();
    check("b2b.st_rvalid", {31'h0, rvalid}, 32'h0);
    we = 1'b0;
    tick();
    req = 1'b0;
    check("b2b.rvalid", {31'h0, rvalid}, 32'h1);
    check("b2b.dout", dout, 32'hA5A5A5A5);

    // Reset arriving before the edge that would accept a load
    st("sw80", 2'b10, 13'h080, 32'h12345678, 1'b0);
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 13'h080;
    #3 rst_n = 1'b0;
    tick();
    check("mid.rvalid", {31'h0, rvalid}, 32'h0);
    check("mid.err", {31'h0, addr_err}, 32'h0);
    check("mid.dout", dout, 32'h0);
    req = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_init("init2");
    ld("post.lw80", 2'b10, 1'b0, 13'h080, 32'h0, 1'b0);
    ld("post.lw40", 2'b10, 1'b0, 13'h040, 32'h0, 1'b0);
    ld("post.lw20", 2'b10, 1'b0, 13'h020, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
